conf_ctx_reg_file: RTL

CONF_CTX_REG_FILE -- requirements
Module: conf_ctx_reg_file

---
 rtl/conf_ctx_reg_file.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/conf_ctx_reg_file.sv
// conf_ctx_reg_file
//   Multi-context configuration store. Each of NUM_CTX contexts holds DEPTH
//   instruction words. Exactly one context is active and feeds the read
//   port. The other contexts can be loaded in the background through a
//   valid/ready port. A small switch FSM moves execution to another context
//   at a safe point, which is a clock-enabled cycle with no read.
//
//   Optional build macro: CONF_CTX_PARITY_EN
//     Defined   -> one even-parity bit is stored per word and checked on every read.
//     Undefined -> no parity storage exists and par_err_o is tied low.
//
//   Ports
//     clk_i, rst_ni        clock, asynchronous active-low reset
//     ce_i                 clock enable for the read and swap paths
//     re_i, global_pc_i    read request and read address in the active context
//     conf_o               registered instruction word
//     conf_valid_o         conf_o was updated this cycle
//     par_err_o            parity error on the current conf_o
//     ld_valid_i/ready_o   load handshake
//     ld_ctx_i/addr_i/data_i  load target and data
//     ld_err_o             one-cycle pulse: an accepted load was out of range and was dropped
//     swap_req_i, swap_ctx_i  context switch request
//     swap_ack_o           one-cycle pulse: switch finished or was a no-op
//     busy_o               a switch is pending
//     active_ctx_o         context that is currently executing
module conf_ctx_reg_file #(
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 32,
  parameter int NUM_CTX     = 2,
  localparam int PC_W       = $clog2(DEPTH),
  localparam int CTX_W      = $clog2(NUM_CTX)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ce_i,
  input  logic                   re_i,
  input  logic [PC_W-1:0]        global_pc_i,
  output logic [INSTR_WIDTH-1:0] conf_o,
  output logic                   conf_valid_o,
  output logic                   par_err_o,
  input  logic                   ld_valid_i,
  output logic                   ld_ready_o,
  input  logic [CTX_W-1:0]       ld_ctx_i,
  input  logic [PC_W-1:0]        ld_addr_i,
  input  logic [INSTR_WIDTH-1:0] ld_data_i,
  output logic                   ld_err_o,
  input  logic                   swap_req_i,
  input  logic [CTX_W-1:0]       swap_ctx_i,
  output logic                   swap_ack_o,
  output logic                   busy_o,
  output logic [CTX_W-1:0]       active_ctx_o
);

  // Bounds are compared with one extra bit, because DEPTH and NUM_CTX can be
  // exact powers of two.
  localparam logic [PC_W:0]  DEPTH_L = DEPTH[PC_W:0];
  localparam logic [CTX_W:0] NCTX_L  = NUM_CTX[CTX_W:0];

  typedef enum logic {RUN, PEND} state_t;

  state_t                   state_q, state_d;
  logic [CTX_W-1:0]         active_ctx_q;
  logic [CTX_W-1:0]         pend_ctx_q;
  logic                     ack_d;
  logic                     latch_pend;
  logic                     commit;

  logic [INSTR_WIDTH-1:0]   mem [NUM_CTX][DEPTH];

  logic                     rd_en;
  logic                     rd_in_range;
  logic [INSTR_WIDTH-1:0]   rd_word;
  logic                     rd_par_err;
  logic                     ld_accept;
  logic                     ld_in_range;
  logic                     swap_ctx_ok;

  assign busy_o       = (state_q == PEND);
  assign active_ctx_o = active_ctx_q;

  // A context that is executing, or that is about to execute, must not be
  // rewritten under the read port.
  assign ld_ready_o  = !((ld_ctx_i == active_ctx_q) ||
                         (busy_o && (ld_ctx_i == pend_ctx_q)));
  assign ld_accept   = ld_valid_i && ld_ready_o;
  assign ld_in_range = ({1'b0, ld_addr_i} < DEPTH_L) && ({1'b0, ld_ctx_i} < NCTX_L);

  assign rd_en       = re_i && ce_i;
  assign rd_in_range = ({1'b0, global_pc_i} < DEPTH_L);
  assign rd_word     = rd_in_range ? mem[active_ctx_q][global_pc_i] : '0;
  assign swap_ctx_ok = ({1'b0, swap_ctx_i} < NCTX_L);

  // Word storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (ld_accept && ld_in_range) begin
      mem[ld_ctx_i][ld_addr_i] <= ld_data_i;
    end
  end

`ifdef CONF_CTX_PARITY_EN
  logic par_mem [NUM_CTX][DEPTH];

  always_ff @(posedge clk_i) begin
    if (ld_accept && ld_in_range) begin
      par_mem[ld_ctx_i][ld_addr_i] <= ^ld_data_i;
    end
  end

  assign rd_par_err = rd_in_range && ((^rd_word) != par_mem[active_ctx_q][global_pc_i]);
`else
  assign rd_par_err = 1'b0;
`endif

  // The switch commits only in an enabled cycle that has no read. As a
  // result, a read never observes a context that changes in the same cycle.
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    latch_pend = 1'b0;
    commit     = 1'b0;
    case (state_q)
      RUN: begin
        if (swap_req_i && ce_i) begin
          if ((swap_ctx_i == active_ctx_q) || !swap_ctx_ok) begin
            ack_d = 1'b1;
          end else begin
            latch_pend = 1'b1;
            state_d    = PEND;
          end
        end
      end
      PEND: begin
        if (ce_i && !re_i) begin
          commit  = 1'b1;
          ack_d   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RUN;
      active_ctx_q <= '0;
      pend_ctx_q   <= '0;
      swap_ack_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      swap_ack_o <= ack_d;
      if (latch_pend) begin
        pend_ctx_q <= swap_ctx_i;
      end
      if (commit) begin
        active_ctx_q <= pend_ctx_q;
      end
    end
  end

  // par_err_o follows conf_o and holds with it between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conf_o       <= '0;
      conf_valid_o <= 1'b0;
      par_err_o    <= 1'b0;
      ld_err_o     <= 1'b0;
    end else begin
      conf_valid_o <= rd_en;
      ld_err_o     <= ld_accept && !ld_in_range;
      if (rd_en) begin
        conf_o    <= rd_word;
        par_err_o <= rd_par_err;
      end
    end
  end

endmodule
